// File: rtl/booth_divider.sv
// booth_divider: sequential radix-2 restoring divider.
// Divides a 2N-bit unsigned dividend by an N-bit unsigned divisor, producing
// one quotient bit per clock. Accepts a full-width multiplier product directly
// and returns quotient and remainder, flagging divide-by-zero and quotient
// overflow without spending any iteration cycles on them.
module booth_divider #(
  parameter int N  = 283,  // divisor / quotient / remainder width
  parameter int CW = 9     // iteration counter width, 2**CW > N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*N-1:0]   a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     q,
  output logic [N-1:0]     r,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e         state_q, state_d;

  // Working operands: captured divisor, partial remainder, dividend/quotient
  // shift register. The remainder never reaches the divisor, so N bits suffice.
  logic [N-1:0]   div_q, div_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Result registers, updated only on the transition into FIN.
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   r_q, r_d;
  logic           err_q, err_d;

  // One restoring step and the start-time overflow test.
  logic [N:0]     shifted;
  logic           step_ge;
  logic [N-1:0]   step_rem;
  logic [N-1:0]   step_quo;
  logic           start_err;
  logic           last_step;

  // A quotient that fits in N bits requires the upper dividend half below b;
  // this comparison also catches b == 0.
  assign start_err = (b == '0) || (a[2*N-1:N] >= b);
  assign last_step = (cnt_q == CW'(1));

  // Shift in the next dividend bit and trial-subtract the divisor. Because the
  // remainder stays below the divisor, the shifted value is below 2*b, so a
  // modulo-2**N subtraction is exact whenever the trial succeeds.
  always_comb begin
    shifted  = {rem_q, quo_q[N-1]};
    step_ge  = shifted[N] || (shifted[N-1:0] >= div_q);
    step_rem = step_ge ? (shifted[N-1:0] - div_q) : shifted[N-1:0];
    step_quo = {quo_q[N-2:0], step_ge};
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = start_err ? FIN : RUN;
      RUN:     if (last_step) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == FIN);
  end

  assign q   = q_q;
  assign r   = r_q;
  assign err = err_q;

  // Datapath next-state: operand capture, iteration, and result latching.
  always_comb begin
    div_d = div_q;
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    q_d   = q_q;
    r_d   = r_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          div_d = b;
          rem_d = a[2*N-1:N];
          quo_d = a[N-1:0];
          cnt_d = CW'(N);
          if (start_err) begin
            q_d   = '1;
            r_d   = '0;
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        if (last_step) begin
          q_d   = step_quo;
          r_d   = step_rem;
          err_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      err_q <= 1'b0;
    end else begin
      div_q <= div_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      q_q   <= q_d;
      r_q   <= r_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// tb_booth_divider: scoreboard bench for booth_divider at N=8 and N=283.
module tb_booth_divider;

  localparam int NS  = 8;
  localparam int CWS = 4;
  localparam int NW  = 283;
  localparam int CWW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Narrow instance
  logic            rst8, start8;
  logic [2*NS-1:0] a8;
  logic [NS-1:0]   b8;
  logic            busy8, done8, err8;
  logic [NS-1:0]   q8, r8;

  // Wide instance
  logic            rstw, startw;
  logic [2*NW-1:0] aw;
  logic [NW-1:0]   bw;
  logic            busyw, donew, errw;
  logic [NW-1:0]   qw, rw;

  booth_divider #(.N(NS), .CW(CWS)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .q(q8), .r(r8), .err(err8)
  );

  booth_divider #(.N(NW), .CW(CWW)) dutw (
    .clk(clk), .rst(rstw), .start(startw), .a(aw), .b(bw),
    .busy(busyw), .done(donew), .q(qw), .r(rw), .err(errw)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [NS-1:0] q;
    logic [NS-1:0] r;
    logic          err;
  } exp8_t;

  typedef struct {
    logic [NW-1:0] q;
    logic [NW-1:0] r;
    logic          err;
  } expw_t;

  exp8_t sb8[$];
  expw_t sbw[$];

  // Reference model: plain integer division with the overflow rule.
  function automatic exp8_t model8(logic [2*NS-1:0] a, logic [NS-1:0] b);
    exp8_t e;
    logic [2*NS-1:0] qq, rr;
    if (b == '0 || a[2*NS-1:NS] >= b) begin
      e.q = '1; e.r = '0; e.err = 1'b1;
    end else begin
      qq = a / {{NS{1'b0}}, b};
      rr = a % {{NS{1'b0}}, b};
      e.q = qq[NS-1:0]; e.r = rr[NS-1:0]; e.err = 1'b0;
    end
    return e;
  endfunction

  function automatic expw_t modelw(logic [2*NW-1:0] a, logic [NW-1:0] b);
    expw_t e;
    logic [2*NW-1:0] qq, rr;
    if (b == '0 || a[2*NW-1:NW] >= b) begin
      e.q = '1; e.r = '0; e.err = 1'b1;
    end else begin
      qq = a / {{NW{1'b0}}, b};
      rr = a % {{NW{1'b0}}, b};
      e.q = qq[NW-1:0]; e.r = rr[NW-1:0]; e.err = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [NW-1:0] randw();
    logic [NW-1:0] v = '0;
    for (int i = 0; i < 9; i++) v = (v << 32) | NW'($urandom());
    return v;
  endfunction

  // Result monitors: every done pulse pops and checks one expected result.
  always @(negedge clk) begin
    exp8_t e;
    if (!rst8 && done8) begin
      vectors++;
      if (sb8.size() == 0) begin
        miscompares++;
        $display("FAIL result8: unexpected done, q=%0d r=%0d err=%0b, none expected", q8, r8, err8);
      end else begin
        e = sb8.pop_front();
        if ({q8, r8, err8} !== {e.q, e.r, e.err}) begin
          miscompares++;
          $display("FAIL result8: got q=%0d r=%0d err=%0b, want q=%0d r=%0d err=%0b",
                   q8, r8, err8, e.q, e.r, e.err);
        end
      end
    end
  end

  always @(negedge clk) begin
    expw_t e;
    if (!rstw && donew) begin
      vectors++;
      if (sbw.size() == 0) begin
        miscompares++;
        $display("FAIL resultw: unexpected done, err=%0b, none expected", errw);
      end else begin
        e = sbw.pop_front();
        if ({qw, rw, errw} !== {e.q, e.r, e.err}) begin
          miscompares++;
          $display("FAIL resultw: got q=%h r=%h err=%0b", qw, rw, errw);
          $display("FAIL resultw: want q=%h r=%h err=%0b", e.q, e.r, e.err);
        end
      end
    end
  end

  task automatic wait_idle8();
    int n = 0;
    @(negedge clk);
    while ((busy8 || done8) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 1000) begin
      miscompares++;
      $display("FAIL idle8: still busy after %0d cycles, want idle", n);
    end
  endtask

  task automatic wait_idlew();
    int n = 0;
    @(negedge clk);
    while ((busyw || donew) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 1000) begin
      miscompares++;
      $display("FAIL idlew: still busy after %0d cycles, want idle", n);
    end
  endtask

  // One operation on the narrow instance with latency and busy-length checks.
  task automatic run_op8(logic [2*NS-1:0] a, logic [NS-1:0] b);
    exp8_t e;
    int    edges, busy_cnt, want;
    bit    seen;
    wait_idle8();
    e = model8(a, b);
    a8 = a; b8 = b; start8 = 1'b1;
    sb8.push_back(e);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = ~a; b8 = ~b;
    edges = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && edges < 1000) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
      else begin
        if (busy8) busy_cnt++;
        @(posedge clk);
        edges++;
      end
    end
    want = e.err ? 0 : NS;
    vectors++;
    if (!seen || edges != want) begin
      miscompares++;
      $display("FAIL latency8 a=%0d b=%0d: done at t+%0d (seen=%0b), want t+%0d", a, b, edges + 1, seen, want + 1);
    end
    vectors++;
    if (busy_cnt != want) begin
      miscompares++;
      $display("FAIL busy8 a=%0d b=%0d: busy for %0d cycles, want %0d", a, b, busy_cnt, want);
    end
  endtask

  task automatic run_opw(logic [2*NW-1:0] a, logic [NW-1:0] b, expw_t e);
    int edges, want;
    bit seen;
    wait_idlew();
    aw = a; bw = b; startw = 1'b1;
    sbw.push_back(e);
    @(posedge clk);
    #1;
    startw = 1'b0;
    aw = ~a; bw = ~b;
    edges = 0; seen = 1'b0;
    while (!seen && edges < 1000) begin
      @(negedge clk);
      if (donew) seen = 1'b1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    want = e.err ? 0 : NW;
    vectors++;
    if (!seen || edges != want) begin
      miscompares++;
      $display("FAIL latencyw: done at t+%0d (seen=%0b), want t+%0d", edges + 1, seen, want + 1);
    end
  endtask

  // Reset clears everything and wins over a simultaneous start.
  task automatic test_reset();
    rst8 = 1'b1; start8 = 1'b1; a8 = 16'd1000; b8 = 8'd7;
    rstw = 1'b1; startw = 1'b0; aw = '0; bw = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy8, done8, err8, q8, r8} !== '0) begin
      miscompares++;
      $display("FAIL reset8: busy=%0b done=%0b err=%0b q=%0d r=%0d, want all 0", busy8, done8, err8, q8, r8);
    end
    vectors++;
    if ({busyw, donew, errw} !== 3'b000 || qw !== '0 || rw !== '0) begin
      miscompares++;
      $display("FAIL resetw: busy=%0b done=%0b err=%0b, want all 0", busyw, donew, errw);
    end
    rst8 = 1'b0; start8 = 1'b0;
    rstw = 1'b0;
  endtask

  task automatic test_basic();
    run_op8(16'd1000, 8'd7);
    run_op8(16'h00FF, 8'h01);
    run_op8(16'h7FFF, 8'h80);
    run_op8(16'h1234, 8'hFE);
    run_op8(16'h0000, 8'h05);
  endtask

  task automatic test_errors();
    run_op8(16'h0100, 8'h01);
    run_op8(16'h5A5A, 8'h00);
    run_op8(16'hFFFF, 8'hFF);
    run_op8(16'd1000, 8'd7);
  endtask

  task automatic test_random();
    logic [NS-1:0] b;
    logic [NS-1:0] hi;
    for (int i = 0; i < 20; i++) begin
      b  = NS'($urandom_range(1, 255));
      hi = NS'($urandom_range(0, int'(b) - 1));
      run_op8({hi, NS'($urandom())}, b);
    end
  endtask

  // start held high with operands changing every cycle; only the values present
  // at each accepting edge (every NS+2 edges) may influence results.
  task automatic test_back_to_back();
    int            stamps[$];
    int            k;
    logic [NS-1:0] b, hi;
    wait_idle8();
    start8 = 1'b1;
    k = 0;
    while (k <= 2 * (NS + 2)) begin
      b  = NS'($urandom_range(1, 255));
      hi = NS'($urandom_range(0, int'(b) - 1));
      a8 = {hi, NS'($urandom())};
      b8 = b;
      if (k % (NS + 2) == 0) sb8.push_back(model8(a8, b8));
      @(posedge clk);
      @(negedge clk);
      if (done8) stamps.push_back(k);
      k++;
    end
    start8 = 1'b0;
    while (k <= 4 * (NS + 2)) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) stamps.push_back(k);
      k++;
    end
    vectors++;
    if (stamps.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_count: %0d done pulses, want 3", stamps.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (stamps[i] != NS + i * (NS + 2)) begin
          miscompares++;
          $display("FAIL b2b_timing[%0d]: done at edge %0d, want %0d", i, stamps[i], NS + i * (NS + 2));
        end
      end
    end
  endtask

  // Reset during RUN cycle 4 aborts the operation without a done pulse.
  task automatic test_reset_midrun();
    int dones = 0;
    wait_idle8();
    a8 = 16'd1000; b8 = 8'd7; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk);
    #1;
    rst8 = 1'b0;
    vectors++;
    if ({busy8, done8, err8, q8, r8} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: busy=%0b done=%0b err=%0b q=%0d r=%0d, want all 0", busy8, done8, err8, q8, r8);
    end
    repeat (NS + 4) begin
      @(negedge clk);
      if (done8) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL midrun_nodone: %0d done pulses, want 0", dones);
    end
    run_op8(16'd1000, 8'd7);
  endtask

  task automatic test_wide();
    logic [NW-1:0]   x, y, hi;
    logic [2*NW-1:0] a;
    expw_t           e;
    for (int i = 0; i < 3; i++) begin
      x = randw();
      y = randw();
      if (y == '0) y = NW'(1);
      a = {{NW{1'b0}}, x} * {{NW{1'b0}}, y};
      e.q = x; e.r = '0; e.err = 1'b0;
      run_opw(a, y, e);
    end
    for (int i = 0; i < 12; i++) begin
      y = randw();
      if (i == 0) y = NW'(3);
      if (y == '0) y = NW'(1);
      hi = randw() % y;
      a  = {hi, randw()};
      run_opw(a, y, modelw(a, y));
    end
    a = {randw(), randw()};
    run_opw(a, '0, modelw(a, '0));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    test_wide();
    wait_idle8();
    wait_idlew();
    vectors++;
    if (sb8.size() != 0) begin
      miscompares++;
      $display("FAIL drain8: %0d results outstanding, want 0", sb8.size());
    end
    vectors++;
    if (sbw.size() != 0) begin
      miscompares++;
      $display("FAIL drainw: %0d results outstanding, want 0", sbw.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
